// File: rtl/udma_hyper_cfg_router.sv
// Config-bus router: steers the uDMA peripheral config port to one of NB_TGT register targets.
// Optional feature macro HYPER_CFG_TIMEOUT_EN aborts a hung target after TIMEOUT_CYCLES with an error.
module udma_hyper_cfg_router #(
  parameter int unsigned           NB_TGT         = 2,
  parameter int unsigned           ADDR_WIDTH     = 6,
  parameter int unsigned           TGT_ADDR_LSB   = 5,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hBADACCE5
) (
  input  logic                              sys_clk_i,
  input  logic                              rstn_i,
  input  logic                              cfg_valid_i,
  input  logic [ADDR_WIDTH-1:0]             cfg_addr_i,
  input  logic                              cfg_rwn_i,
  input  logic [DATA_WIDTH-1:0]             cfg_data_i,
  output logic                              cfg_ready_o,
  output logic [DATA_WIDTH-1:0]             cfg_data_o,
  output logic                              cfg_err_o,
  output logic [NB_TGT-1:0]                 tgt_valid_o,
  output logic [TGT_ADDR_LSB-1:0]           tgt_addr_o,
  output logic                              tgt_rwn_o,
  output logic [DATA_WIDTH-1:0]             tgt_data_o,
  input  logic [NB_TGT-1:0]                 tgt_ready_i,
  input  logic [NB_TGT-1:0][DATA_WIDTH-1:0] tgt_rdata_i,
  output logic                              busy_o,
  output logic [7:0]                        err_cnt_o
);
  localparam int unsigned IDX_W = ADDR_WIDTH - TGT_ADDR_LSB;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TGT_ADDR_LSB-1:0] addr_q, addr_d;
  logic                    rwn_q, rwn_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q;

  logic [NB_TGT-1:0]       sel;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    mapped;
  logic                    timeout;

  // Request strobe comes only from registered state, so non-selected ready bits mask out naturally.
  assign sel       = (state_q == REQ) ? (NB_TGT'(1) << idx_q) : '0;
  assign sel_ready = |(tgt_ready_i & sel);
  assign mapped    = 32'(cfg_addr_i[ADDR_WIDTH-1:TGT_ADDR_LSB]) < NB_TGT;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NB_TGT; i++) begin
      if (sel[i]) sel_rdata = tgt_rdata_i[i];
    end
  end

`ifdef HYPER_CFG_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Counter sits at zero outside REQ, so every REQ entry starts a fresh count.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i || state_q != REQ) tmo_cnt_q <= '0;
    else                           tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign timeout = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rwn_d   = rwn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          idx_d   = cfg_addr_i[ADDR_WIDTH-1:TGT_ADDR_LSB];
          addr_d  = cfg_addr_i[TGT_ADDR_LSB-1:0];
          rwn_d   = cfg_rwn_i;
          wdata_d = cfg_data_i;
          if (mapped) begin
            state_d = REQ;
          end else begin
            state_d = RSP;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
          end
        end
      end
      REQ: begin
        // A ready arriving in the final timeout cycle still completes normally.
        if (sel_ready) begin
          state_d = RSP;
          err_d   = 1'b0;
          rdata_d = rwn_q ? sel_rdata : '0;
        end else if (timeout) begin
          state_d = RSP;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      rwn_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rwn_q   <= rwn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == RSP && err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign cfg_ready_o = (state_q == RSP);
  assign cfg_data_o  = rdata_q;
  assign cfg_err_o   = err_q;
  assign tgt_valid_o = sel;
  assign tgt_addr_o  = addr_q;
  assign tgt_rwn_o   = rwn_q;
  assign tgt_data_o  = wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign err_cnt_o   = err_cnt_q;

endmodule
